pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the ID->IE pipeline register and keeps the pipeline correct without software NOPs.
//  Per cycle it decides three things: whether IF and ID stall, whether a bubble is written into ID/IE,
//  and which forwarding source drives op1/op2.
//  Holds a 3-deep destination scoreboard (IE, MEM, WB), a multi-cycle busy counter and a branch-flush counter.
// PARAMETERS
//  REG_W         4  register-index width (16 regs; r0 hardwired zero)
//  OP_W          8  opcode width
//  MC_LAT        4  cycles a multi-cycle op (MUL/DIV) occupies IE; legal range 2..15
//  FLUSH_CYCLES  2  cycles flush_if_id is held after a taken branch; legal range 1..3
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      synchronous active-low reset
//  id_valid       in   1      ID holds a valid instruction
//  id_opcode      in   OP_W   ID opcode
//  id_src1        in   REG_W  ID source reg 1
//  id_src1_used   in   1      src1 is read
//  id_src2        in   REG_W  ID source reg 2
//  id_src2_used   in   1      src2 is read
//  id_wb_reg      in   REG_W  ID destination reg
//  id_wb_en       in   1      ID instruction writes back
//  ie_branch_tkn  in   1      IE resolved a taken branch this cycle
//  stall_if       out  1      hold PC and IF/ID
//  stall_id       out  1      hold ID; no issue this cycle
//  bubble_ie      out  1      load NOP (opcode 0, wb_en 0) into ID/IE
//  flush_if_id    out  1      kill IF/ID contents
//  fwd_op1_sel    out  2      00 regfile, 01 IE result, 10 MEM result, 11 WB result
//  fwd_op2_sel    out  2      same encoding for op2
//  ie_busy        out  1      multi-cycle op in progress (mc_cnt != 0)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): scoreboard entries invalid, mc_cnt=0, fl_cnt=0.
//    While rst_n=0, all outputs are forced to 0 regardless of inputs.
//  Scoreboard entry = {vld, reg, is_ld}. An entry is valid only if wb_en=1 and reg!=0.
//    r0 never matches anything.
//  Outputs are combinational from the inputs plus registered state; zero-cycle decision latency.
//  flush  = ie_branch_tkn | (fl_cnt != 0)
//  ld_use = id_valid & a used src equals IE.reg & IE.vld & IE.is_ld
//  busy   = mc_cnt != 0
//  stall_id = stall_if = ~flush & (ld_use | busy)
//  bubble_ie = flush | ld_use | busy;  flush_if_id = flush
//  issue = id_valid & ~stall_id & ~flush
//  Forwarding, per used src: priority IE > MEM > WB (youngest wins); otherwise 00.
//    The load-use case forces 00 because the stall covers it.
//  Posedge update:
//    - If busy: mc_cnt--. IE entry holds. MEM<=invalid. WB<=MEM.
//    - Else: WB<=MEM; MEM<=IE; IE<=issue ? {id_wb_en & id_wb_reg!=0, id_wb_reg, is_load(op)} : invalid.
//    - On issue of is_multicycle(op): mc_cnt<=MC_LAT-1.
//  ie_branch_tkn is ignored while busy (IE holds a MUL/DIV, not a branch).
//    When accepted: fl_cnt<=FLUSH_CYCLES-1. Otherwise, if fl_cnt!=0: fl_cnt--.
//  Simultaneous events:
//    - flush beats ld_use/busy-stall: stall=0, bubble=1, no issue.
//    - Branch during ld_use: flush wins and the ld_use stall is dropped.
//  A new taken branch while fl_cnt!=0 reloads fl_cnt.
//  Reset mid multi-cycle op or mid flush: counters clear on that edge; no residual stall.
// STRUCTURE
//  Package risc_pipe_pkg holds:
//    OP_LOAD=8'h20, OP_MUL=8'h30, OP_DIV=8'h31, NOP=8'h00
//    FWD_RF/FWD_IE/FWD_MEM/FWD_WB localparams
//    functions is_load(), is_multicycle()
//  Sub-module pipe_scoreboard: the 3-entry shift with hold/insert-bubble controls and a match port per source.
//    Instantiated once; hazard logic and counters live in the top.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with id_valid=1, ie_branch_tkn=1 -> all outputs 0.
//    After release, ADD r1 sees fwd 00.
//  2 RAW forward: ADD wb r3, then src1=r3 on the next three consecutive issues -> fwd_op1_sel 01, 10, 11.
//    Fourth issue -> 00. No stall throughout.
//  3 Load-use: LOAD wb r5, then ADD src2=r5 -> stall_id=stall_if=bubble_ie=1 for exactly 1 cycle.
//    ADD then issues with fwd_op2_sel=10.
//  4 Multi-cycle: MUL wb r7 with MC_LAT=4 -> ie_busy/stall_id high 3 cycles.
//    Dependent ADD src1=r7 then gets fwd 01.
//  5 Branch vs stall: ie_branch_tkn=1 in the same cycle as a load-use hazard, FLUSH_CYCLES=2
//    -> flush_if_id=1 for 2 cycles, stall_id=0, bubble_ie=1, no issue.
//  6 r0: LOAD wb r0, then src1=r0 -> no stall, fwd 00.
//    Then mid-MUL (mc_cnt=2) assert rst_n=0 -> next cycle ie_busy=0, stall_id=0.

Source files
------------

// File: rtl/risc_pipe_pkg.sv
// Shared opcodes, forwarding-select encodings and opcode classifiers
// for the ID->IE hazard controller.
package risc_pipe_pkg;

    localparam logic [7:0] NOP     = 8'h00;
    localparam logic [7:0] OP_LOAD = 8'h20;
    localparam logic [7:0] OP_MUL  = 8'h30;
    localparam logic [7:0] OP_DIV  = 8'h31;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_IE  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    function automatic logic is_load(input logic [7:0] op);
        return op == OP_LOAD;
    endfunction

    function automatic logic is_multicycle(input logic [7:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Three-entry destination scoreboard (IE, MEM, WB) with hold and
// insert controls; ports: ins_* new IE entry, src1/src2 lookups, m1/m2 hits.
module pipe_scoreboard #(
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             ins_vld,
    input  logic [REG_W-1:0] ins_reg,
    input  logic             ins_ld,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    output logic [2:0]       m1,
    output logic [2:0]       m2,
    output logic             ie_ld
);

    logic [2:0]       vld_q, vld_d;
    logic [2:0]       ld_q, ld_d;
    logic [REG_W-1:0] reg_q [3];
    logic [REG_W-1:0] reg_d [3];

    // index 0 = IE, 1 = MEM, 2 = WB
    always_comb begin
        vld_d = vld_q;
        ld_d  = ld_q;
        reg_d = reg_q;
        vld_d[2] = vld_q[1];
        ld_d[2]  = ld_q[1];
        reg_d[2] = reg_q[1];
        if (hold) begin
            // IE keeps its multi-cycle op; MEM drains to a bubble
            vld_d[1] = 1'b0;
        end else begin
            vld_d[1] = vld_q[0];
            ld_d[1]  = ld_q[0];
            reg_d[1] = reg_q[0];
            vld_d[0] = ins_vld;
            ld_d[0]  = ins_ld;
            reg_d[0] = ins_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            ld_q  <= '0;
            for (int i = 0; i < 3; i++) reg_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            ld_q  <= ld_d;
            reg_q <= reg_d;
        end
    end

    // valid entries never carry r0, so r0 cannot hit
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            m1[i] = vld_q[i] && (reg_q[i] == src1);
            m2[i] = vld_q[i] && (reg_q[i] == src2);
        end
    end

    assign ie_ld = ld_q[0];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID->IE hazard controller: stall, bubble, flush and operand forwarding
// from a destination scoreboard, a multi-cycle busy and a flush counter.
module pipe_hazard_ctrl
    import risc_pipe_pkg::*;
#(
    parameter int REG_W        = 4,
    parameter int OP_W         = 8,
    parameter int MC_LAT       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [OP_W-1:0]  id_opcode,
    input  logic [REG_W-1:0] id_src1,
    input  logic             id_src1_used,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src2_used,
    input  logic [REG_W-1:0] id_wb_reg,
    input  logic             id_wb_en,
    input  logic             ie_branch_tkn,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ie,
    output logic             flush_if_id,
    output logic [1:0]       fwd_op1_sel,
    output logic [1:0]       fwd_op2_sel,
    output logic             ie_busy
);

    localparam logic [3:0] MC_INIT = 4'(MC_LAT - 1);
    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);

    logic [3:0] mc_cnt_q, mc_cnt_d;
    logic [1:0] fl_cnt_q, fl_cnt_d;

    logic [2:0] m1, m2;
    logic       ie_ld;
    logic       busy, br_acc, flush;
    logic       u1, u2, ld_use, stall, issue;
    logic       ins_vld;
    logic [7:0] op8;

    assign op8 = 8'(id_opcode);

    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [2:0] m,
        input logic       ld
    );
        if (!used)     return FWD_RF;
        // load in IE is a stall, not a forward
        if (m[0])      return ld ? FWD_RF : FWD_IE;
        if (m[1])      return FWD_MEM;
        if (m[2])      return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        busy    = mc_cnt_q != 4'd0;
        // IE holds a MUL/DIV while busy, so no branch can resolve
        br_acc  = ie_branch_tkn & ~busy;
        flush   = br_acc | (fl_cnt_q != 2'd0);
        u1      = id_valid & id_src1_used;
        u2      = id_valid & id_src2_used;
        ld_use  = ie_ld & ((u1 & m1[0]) | (u2 & m2[0]));
        stall   = ~flush & (ld_use | busy);
        issue   = id_valid & ~stall & ~flush;
        ins_vld = issue & id_wb_en & (id_wb_reg != '0);

        mc_cnt_d = mc_cnt_q;
        if (busy)
            mc_cnt_d = mc_cnt_q - 4'd1;
        else if (issue && is_multicycle(op8))
            mc_cnt_d = MC_INIT;

        fl_cnt_d = fl_cnt_q;
        if (br_acc)
            fl_cnt_d = FL_INIT;
        else if (fl_cnt_q != 2'd0)
            fl_cnt_d = fl_cnt_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mc_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            mc_cnt_q <= mc_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    pipe_scoreboard #(
        .REG_W (REG_W)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (busy),
        .ins_vld (ins_vld),
        .ins_reg (id_wb_reg),
        .ins_ld  (is_load(op8)),
        .src1    (id_src1),
        .src2    (id_src2),
        .m1      (m1),
        .m2      (m2),
        .ie_ld   (ie_ld)
    );

    // everything reads as zero while reset is held
    always_comb begin
        stall_if    = rst_n & stall;
        stall_id    = rst_n & stall;
        bubble_ie   = rst_n & (flush | ld_use | busy);
        flush_if_id = rst_n & flush;
        ie_busy     = rst_n & busy;
        fwd_op1_sel = rst_n ? fwd_sel(u1, m1, ie_ld) : FWD_RF;
        fwd_op2_sel = rst_n ? fwd_sel(u2, m2, ie_ld) : FWD_RF;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard sequences
// followed by random traffic against an instruction-level reference model.
module tb_pipe_hazard_ctrl;
    import risc_pipe_pkg::*;

    localparam int MC_LAT = 4;
    localparam int FC     = 2;
    localparam logic [7:0] ADD = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [7:0] id_opcode = '0;
    logic [3:0] id_src1 = '0, id_src2 = '0, id_wb_reg = '0;
    logic       id_src1_used = 1'b0, id_src2_used = 1'b0;
    logic       id_wb_en = 1'b0, ie_branch_tkn = 1'b0;
    logic       stall_if, stall_id, bubble_ie, flush_if_id, ie_busy;
    logic [1:0] fwd_op1_sel, fwd_op2_sel;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W(4), .OP_W(8), .MC_LAT(MC_LAT), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_opcode(id_opcode),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_wb_reg(id_wb_reg), .id_wb_en(id_wb_en),
        .ie_branch_tkn(ie_branch_tkn),
        .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ie(bubble_ie), .flush_if_id(flush_if_id),
        .fwd_op1_sel(fwd_op1_sel), .fwd_op2_sel(fwd_op2_sel),
        .ie_busy(ie_busy)
    );

    typedef struct {
        int         cyc;
        logic [4:0] ctrl;
        bit         chk_fwd;
        logic [1:0] f1;
        logic [1:0] f2;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference: in-flight producers, youngest first (0 = just issued)
    bit pv[3];
    int pr[3];
    bit pl[3];
    int busy_left = 0;
    int fl_left   = 0;

    function automatic logic [1:0] fwd_of(int src, bit used);
        if (!used) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (pv[k] && pr[k] == src)
                return (k == 0 && pl[0]) ? 2'd0 : 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic bit load_hit(int src, bit used);
        return used && pv[0] && pl[0] && pr[0] == src;
    endfunction

    task automatic step(bit rn, bit v, logic [7:0] op,
                        int s1, bit u1, int s2, bit u2,
                        int wb, bit we, bit br);
        exp_t e;
        bit   busy, brk, flush, lu, stall, issue;
        @(posedge clk);
        #1;
        cyc++;
        rst_n         = rn;
        id_valid      = v;
        id_opcode     = op;
        id_src1       = 4'(s1);
        id_src1_used  = u1;
        id_src2       = 4'(s2);
        id_src2_used  = u2;
        id_wb_reg     = 4'(wb);
        id_wb_en      = we;
        ie_branch_tkn = br;
        e.cyc = cyc;
        if (!rn) begin
            e.ctrl    = '0;
            e.chk_fwd = 1'b1;
            e.f1      = 2'd0;
            e.f2      = 2'd0;
            q.push_back(e);
            for (int k = 0; k < 3; k++) pv[k] = 1'b0;
            busy_left = 0;
            fl_left   = 0;
            return;
        end
        busy  = busy_left > 0;
        brk   = br && !busy;
        flush = brk || fl_left > 0;
        lu    = v && (load_hit(s1, u1) || load_hit(s2, u2));
        stall = !flush && (lu || busy);
        issue = v && !stall && !flush;
        e.ctrl    = {stall, stall, flush || lu || busy, flush, busy};
        e.chk_fwd = issue;
        e.f1      = fwd_of(s1, v && u1);
        e.f2      = fwd_of(s2, v && u2);
        q.push_back(e);
        pv[2] = pv[1]; pr[2] = pr[1]; pl[2] = pl[1];
        if (busy) begin
            pv[1] = 1'b0;
            busy_left--;
        end else begin
            pv[1] = pv[0]; pr[1] = pr[0]; pl[1] = pl[0];
            pv[0] = issue && we && wb != 0;
            pr[0] = wb;
            pl[0] = op == OP_LOAD;
            if (issue && (op == OP_MUL || op == OP_DIV))
                busy_left = MC_LAT - 1;
        end
        if (brk) fl_left = FC - 1;
        else if (fl_left > 0) fl_left--;
    endtask

    task automatic idle();
        step(1, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [4:0] got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {stall_if, stall_id, bubble_ie, flush_if_id, ie_busy};
            tests++;
            if (got !== e.ctrl) begin
                fails++;
                $display("FAIL ctrl cyc=%0d got=%b exp=%b",
                         e.cyc, got, e.ctrl);
            end
            if (e.chk_fwd) begin
                tests++;
                if ({fwd_op1_sel, fwd_op2_sel} !== {e.f1, e.f2}) begin
                    fails++;
                    $display("FAIL fwd cyc=%0d got=%b/%b exp=%b/%b",
                             e.cyc, fwd_op1_sel, fwd_op2_sel, e.f1, e.f2);
                end
            end
        end
    end

    initial begin
        logic [7:0] ops [6];
        ops = '{ADD, ADD, OP_LOAD, OP_MUL, OP_DIV, 8'h02};

        // 1 reset with active inputs, then a plain ADD
        step(0, 1, ADD, 1, 1, 2, 1, 1, 1, 1);
        step(0, 1, ADD, 1, 1, 2, 1, 1, 1, 1);
        step(1, 1, ADD, 1, 1, 0, 0, 2, 1, 0);
        idle(); idle(); idle();

        // 2 RAW forwarding through IE, MEM, WB, then regfile
        step(1, 1, ADD, 1, 1, 0, 0, 3, 1, 0);
        for (int i = 0; i < 4; i++)
            step(1, 1, ADD, 3, 1, 0, 0, 4 + i, 1, 0);
        idle(); idle(); idle();

        // 3 load-use: one stall then MEM forward
        step(1, 1, OP_LOAD, 1, 1, 0, 0, 5, 1, 0);
        step(1, 1, ADD, 1, 1, 5, 1, 9, 1, 0);
        step(1, 1, ADD, 1, 1, 5, 1, 9, 1, 0);
        idle(); idle(); idle();

        // 4 multi-cycle op then dependent ADD
        step(1, 1, OP_MUL, 1, 1, 2, 1, 7, 1, 0);
        for (int i = 0; i < 4; i++)
            step(1, 1, ADD, 7, 1, 0, 0, 10, 1, 0);
        idle(); idle(); idle();

        // 5 branch in the same cycle as a load-use hazard
        step(1, 1, OP_LOAD, 1, 1, 0, 0, 6, 1, 0);
        step(1, 1, ADD, 6, 1, 0, 0, 11, 1, 1);
        step(1, 1, ADD, 6, 1, 0, 0, 11, 1, 0);
        step(1, 1, ADD, 6, 1, 0, 0, 11, 1, 0);
        idle(); idle(); idle();

        // 6 r0 never hazards; reset mid multi-cycle op
        step(1, 1, OP_LOAD, 1, 1, 0, 0, 0, 1, 0);
        step(1, 1, ADD, 0, 1, 0, 0, 12, 1, 0);
        step(1, 1, OP_MUL, 1, 1, 0, 0, 7, 1, 0);
        step(1, 1, ADD, 7, 1, 0, 0, 13, 1, 0);
        step(0, 1, ADD, 7, 1, 0, 0, 13, 1, 0);
        step(1, 1, ADD, 7, 1, 0, 0, 13, 1, 0);
        idle(); idle();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 63) != 0,
                 $urandom_range(0, 3) != 0,
                 ops[$urandom_range(0, 5)],
                 $urandom_range(0, 5), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 5), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 5), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
